// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic light sequencer.
// Lamp vectors are ordered {R, Y, G}.
package tl_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } tl_state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic logic [2:0] lamp_of(input tl_state_e st);
    logic [2:0] lamps;
    unique case (st)
      ST_GREEN:  lamps = LAMP_GRN;
      ST_YELLOW: lamps = LAMP_YEL;
      default:   lamps = LAMP_RED;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/tl_timer.sv
// Phase dwell down counter: load has priority, then hold, then decrement.
// Sync active-high reset to a parameterised start value.
module tl_timer #(
  parameter int unsigned CW = 8,
  parameter logic [CW-1:0] ResetVal = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          hold_i,
  input  logic          dec_i,
  output logic [CW-1:0] value_o,
  output logic          zero_o
);

  logic [CW-1:0] value_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= ResetVal;
    end else if (load_i) begin
      value_q <= load_val_i;
    end else if (dec_i && !hold_i && (value_q != '0)) begin
      value_q <= value_q - 1'b1;
    end
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// RED -> GREEN -> YELLOW sequencer with programmable dwell and forced-red request.
// Lamps are a registered decode of the state, so exactly one is lit every cycle.
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned T_RED    = 30,
  parameter int unsigned T_GREEN  = 25,
  parameter int unsigned T_YELLOW = 5,
  parameter int unsigned CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tick,
  input  logic          force_red,
  output logic          R,
  output logic          Y,
  output logic          G,
  output logic [CW-1:0] remain,
  output logic          phase_done
);

  localparam logic [CW-1:0] RldRed    = CW'(T_RED - 1);
  localparam logic [CW-1:0] RldGreen  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] RldYellow = CW'(T_YELLOW - 1);

  tl_state_e     state_q, state_d;
  logic [2:0]    lamps_q;
  logic          phase_done_q;
  logic          load;
  logic [CW-1:0] load_val;
  logic          zero;
  logic          adv;

  assign adv = en & tick;

  // Any phase change reloads the timer; otherwise the timer counts on tick while en=1.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = RldRed;
    unique case (state_q)
      ST_RED: begin
        if (force_red) begin
          load     = 1'b1;
          load_val = RldRed;
        end else if (adv && zero) begin
          state_d  = ST_GREEN;
          load     = 1'b1;
          load_val = RldGreen;
        end
      end
      ST_GREEN: begin
        if (force_red || (adv && zero)) begin
          state_d  = ST_YELLOW;
          load     = 1'b1;
          load_val = RldYellow;
        end
      end
      ST_YELLOW: begin
        if (adv && zero) begin
          state_d  = ST_RED;
          load     = 1'b1;
          load_val = RldRed;
        end
      end
      default: begin
        state_d  = ST_RED;
        load     = 1'b1;
        load_val = RldRed;
      end
    endcase
  end

  tl_timer #(
    .CW       (CW),
    .ResetVal (RldRed)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .load_val_i (load_val),
    .hold_i     (~en),
    .dec_i      (tick),
    .value_o    (remain),
    .zero_o     (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RED;
      lamps_q      <= LAMP_RED;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lamps_q      <= lamp_of(state_d);
      phase_done_q <= (state_d != state_q);
    end
  end

  assign R          = lamps_q[2];
  assign Y          = lamps_q[1];
  assign G          = lamps_q[0];
  assign phase_done = phase_done_q;

endmodule
